// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and datapath-select encodings for multicycle_control.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_LD  = 7'd3;
    localparam logic [6:0] OP_SD  = 7'd35;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;
    localparam logic [1:0] ALU_I   = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       illegal;
        logic       mem_err;
        logic       retire;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory-request cycles and flags the timeout cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    input  logic i_done,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_stall;

    assign w_stall   = i_active && !i_done;
    assign o_expired = w_stall && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (w_stall && r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle RV64 datapath.
// Optional JAL support is enabled by defining JAL_EN.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_i_or_d,
    output logic       o_ir_write,
    output logic       o_pc_write,
    output logic       o_pc_src,
    output logic [1:0] o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic       o_reg_write,
    output logic [1:0] o_mem_to_reg,
    output logic       o_illegal,
    output logic       o_mem_err,
    output logic       o_retire
);

    state_e r_state, w_next;
    logic   r_abort;
    ctrl_t  w_ctrl, w_out;
    logic   w_req, w_expired, w_clear, w_legal;

    // The cycle after an abort keeps mem_req low so the memory sees a fresh request.
    assign w_req   = (r_state == S_FETCH || r_state == S_MEM) && !r_abort;
    assign w_clear = (w_next != r_state) || w_ctrl.mem_err;

`ifdef JAL_EN
    assign w_legal = i_opcode inside {OP_R, OP_I, OP_LD, OP_SD, OP_BEQ, OP_JAL};
`else
    assign w_legal = i_opcode inside {OP_R, OP_I, OP_LD, OP_SD, OP_BEQ};
`endif

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_active  (w_req),
        .i_done    (i_mem_ready),
        .i_clear   (w_clear),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        r_state <= !rst_n ? S_FETCH : w_next;
        r_abort <= rst_n && w_ctrl.mem_err;
    end

    always_comb begin
        w_ctrl = '0;
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_req   = w_req;
                w_ctrl.alu_src_b = SRCB_FOUR;
                if (w_req && i_mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next          = S_DECODE;
                end else if (w_expired) begin
                    w_ctrl.mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.illegal   = !w_legal;
                w_next           = w_legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (i_opcode)
                    OP_R: begin
                        w_ctrl.alu_src_a = SRCA_RS1;
                        w_ctrl.alu_op    = ALU_R;
                        w_next           = S_WB;
                    end
                    OP_I: begin
                        w_ctrl.alu_src_a = SRCA_RS1;
                        w_ctrl.alu_src_b = SRCB_IMM;
                        w_ctrl.alu_op    = ALU_I;
                        w_next           = S_WB;
                    end
                    OP_LD, OP_SD: begin
                        w_ctrl.alu_src_a = SRCA_RS1;
                        w_ctrl.alu_src_b = SRCB_IMM;
                        w_next           = S_MEM;
                    end
                    OP_BEQ: begin
                        w_ctrl.alu_src_a = SRCA_RS1;
                        w_ctrl.alu_op    = ALU_SUB;
                        w_ctrl.pc_src    = 1'b1;
                        w_ctrl.pc_write  = i_zero;
                        w_ctrl.retire    = 1'b1;
                    end
`ifdef JAL_EN
                    OP_JAL: begin
                        w_ctrl.pc_src   = 1'b1;
                        w_ctrl.pc_write = 1'b1;
                        w_next          = S_WB;
                    end
`endif
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_ctrl.mem_req = w_req;
                w_ctrl.i_or_d  = 1'b1;
                w_ctrl.mem_we  = (i_opcode == OP_SD);
                if (w_req && i_mem_ready) begin
                    w_ctrl.retire = (i_opcode == OP_SD);
                    w_next        = (i_opcode == OP_SD) ? S_FETCH : S_WB;
                end else if (w_expired) begin
                    w_ctrl.mem_err = 1'b1;
                    w_next         = S_FETCH;
                end
            end
            S_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = (i_opcode == OP_LD) ? WB_MDR : WB_ALU;
`ifdef JAL_EN
                if (i_opcode == OP_JAL)
                    w_ctrl.mem_to_reg = WB_PC;
`endif
                w_ctrl.retire     = 1'b1;
                w_next            = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_out        = rst_n ? w_ctrl : '0;
    assign o_mem_req    = w_out.mem_req;
    assign o_mem_we     = w_out.mem_we;
    assign o_i_or_d     = w_out.i_or_d;
    assign o_ir_write   = w_out.ir_write;
    assign o_pc_write   = w_out.pc_write;
    assign o_pc_src     = w_out.pc_src;
    assign o_alu_src_a  = w_out.alu_src_a;
    assign o_alu_src_b  = w_out.alu_src_b;
    assign o_alu_op     = w_out.alu_op;
    assign o_reg_write  = w_out.reg_write;
    assign o_mem_to_reg = w_out.mem_to_reg;
    assign o_illegal    = w_out.illegal;
    assign o_mem_err    = w_out.mem_err;
    assign o_retire     = w_out.retire;

endmodule
